iobus_router: RTL and testbench

Parametrised MicroBlaze MCS IO bus router: decodes a single master transaction onto one of `SLAVE_COUNT` equally strided slave windows, forwards it with registered strobes, and returns the selected slave's response. Unmapped addresses, and optionally slaves that never respond, complete with read data `32'hffffffff`. It sits between the MCS IO port and the peripheral cores (PDM, PRNG, SDRAM bridge). It generalises the fixed core mux with run-time-safe timeout, an error pulse and arbitrary slave count.

---
 rtl/iobus_pkg.sv | 33 +++
 rtl/iobus_router_if.sv | 54 +++++
 rtl/iobus_addr_decode.sv | 28 ++
 rtl/iobus_router.sv | 159 +++++++++++++++
 tb/tb_iobus_router.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iobus_pkg.sv
// iobus_pkg: shared types and constants for the MCS IO bus router and the
// peripheral cores that sit behind it.
package iobus_pkg;

  // Read data returned for unmapped addresses and forced completions.
  localparam logic [31:0] IOBUS_ERR_DATA = 32'hffffffff;

  // Router transaction FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } iobus_router_state_t;

  // Transfer direction, latched at decode time.
  typedef enum logic {
    IOBUS_READ  = 1'b0,
    IOBUS_WRITE = 1'b1
  } iobus_dir_t;

  // Strobe bundle as seen by a single slave core.
  typedef struct packed {
    logic addr_strobe;
    logic read_strobe;
    logic write_strobe;
  } iobus_strobe_t;

  // Width of an index able to address n items, never less than one bit.
  function automatic int iobus_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iobus_router_if.sv
// iobus_router_if: MCS IO bus on the master side plus the fanned-out
// per-slave strobe/response bus, bundled for the router.
//
// Handshake: the master issues io_addr_strobe together with exactly one of
// io_read_strobe/io_write_strobe as a one-cycle pulse and issues nothing else
// until io_ready pulses for one cycle; io_read_data is meaningful only in
// that io_ready cycle. Towards slave k the router pulses s_addr_strobe[k]
// with s_read_strobe[k] or s_write_strobe[k] for one cycle, and slave k
// completes with a one-cycle s_ready[k] (carrying read data in its slot of
// s_read_data) in that cycle or any later one. bus_err pulses only together
// with io_ready.
interface iobus_router_if #(
  parameter int SLAVE_COUNT = 4,
  parameter int OFFSET_W    = 12
);
  logic                      io_addr_strobe;
  logic                      io_read_strobe;
  logic                      io_write_strobe;
  logic [31:0]               io_address;
  logic [3:0]                io_byte_enable;
  logic [31:0]               io_write_data;
  logic [31:0]               io_read_data;
  logic                      io_ready;
  logic                      bus_err;

  logic [SLAVE_COUNT-1:0]    s_addr_strobe;
  logic [SLAVE_COUNT-1:0]    s_read_strobe;
  logic [SLAVE_COUNT-1:0]    s_write_strobe;
  logic [OFFSET_W-1:0]       s_address;
  logic [3:0]                s_byte_enable;
  logic [31:0]               s_write_data;
  logic [32*SLAVE_COUNT-1:0] s_read_data;
  logic [SLAVE_COUNT-1:0]    s_ready;

  // Router view: slave of the MCS, driver of the peripheral strobes.
  modport slave (
    input  io_addr_strobe, io_read_strobe, io_write_strobe,
    input  io_address, io_byte_enable, io_write_data,
    output io_read_data, io_ready, bus_err,
    output s_addr_strobe, s_read_strobe, s_write_strobe,
    output s_address, s_byte_enable, s_write_data,
    input  s_read_data, s_ready
  );

  // Environment view: MCS master plus the peripheral responders.
  modport master (
    output io_addr_strobe, io_read_strobe, io_write_strobe,
    output io_address, io_byte_enable, io_write_data,
    input  io_read_data, io_ready, bus_err,
    input  s_addr_strobe, s_read_strobe, s_write_strobe,
    input  s_address, s_byte_enable, s_write_data,
    output s_read_data, s_ready
  );
endinterface

// File: rtl/iobus_addr_decode.sv
// iobus_addr_decode: combinational window decode. Addresses below the base
// are caught by the borrow of the 33-bit subtraction; addresses above the
// last window are caught by the window index compare, so nothing aliases.
module iobus_addr_decode
  import iobus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'hC0000000,
  parameter logic [31:0] ADDRESS_STRIDE = 32'h1000,
  parameter int          SLAVE_COUNT    = 4,
  localparam int         OFFSET_W       = $clog2(ADDRESS_STRIDE),
  localparam int         SEL_W          = iobus_idx_w(SLAVE_COUNT)
) (
  input  logic [31:0]         i_address,
  output logic                o_hit,
  output logic [SEL_W-1:0]    o_sel,
  output logic [OFFSET_W-1:0] o_offset
);

  logic [32:0] w_diff;
  logic [31:0] w_window;

  assign w_diff   = {1'b0, i_address} - {1'b0, BASE_ADDRESS};
  assign w_window = w_diff[31:0] >> OFFSET_W;
  assign o_hit    = ~w_diff[32] & (w_window < 32'(SLAVE_COUNT));
  assign o_sel    = w_window[SEL_W-1:0];
  assign o_offset = w_diff[OFFSET_W-1:0];

endmodule

// File: rtl/iobus_router.sv
// iobus_router: routes one MCS IO transaction at a time to one of
// SLAVE_COUNT equally strided slave windows and returns its response.
// Unmapped addresses complete immediately with IOBUS_ERR_DATA and bus_err.
// Optional feature macro: IOBUS_ROUTER_TIMEOUT_EN -- forces an error
// completion after TIMEOUT_CYCLES busy cycles without a slave response.
module iobus_router
  import iobus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'hC0000000,
  parameter logic [31:0] ADDRESS_STRIDE = 32'h1000,
  parameter int          SLAVE_COUNT    = 4,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                io_clk,
  input  logic                io_rst,
  iobus_router_if.slave       bus,
  output iobus_router_state_t o_dbg_state
);

  localparam int OFFSET_W = $clog2(ADDRESS_STRIDE);
  localparam int SEL_W    = iobus_idx_w(SLAVE_COUNT);

  // Elaboration-time sanity check of the configuration.
  if ((SLAVE_COUNT < 1) || (SLAVE_COUNT > 16) || (ADDRESS_STRIDE < 32'd4) ||
      ((ADDRESS_STRIDE & (ADDRESS_STRIDE - 32'd1)) != 32'd0) ||
      (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("iobus_router: illegal parameter combination");
  end

  iobus_router_state_t    r_state;
  logic [SEL_W-1:0]       r_sel;
  iobus_dir_t             r_dir;
  logic                   r_io_ready;
  logic                   r_bus_err;
  logic [31:0]            r_io_read_data;
  logic [SLAVE_COUNT-1:0] r_s_addr_strobe;
  logic [SLAVE_COUNT-1:0] r_s_read_strobe;
  logic [SLAVE_COUNT-1:0] r_s_write_strobe;
  logic [OFFSET_W-1:0]    r_s_address;
  logic [3:0]             r_s_byte_enable;
  logic [31:0]            r_s_write_data;

  logic                   w_hit;
  logic [SEL_W-1:0]       w_sel;
  logic [OFFSET_W-1:0]    w_offset;
  logic                   w_req;
  logic [SLAVE_COUNT-1:0] w_sel_onehot;
  logic                   w_sel_ready;
  logic [31:0]            w_sel_rdata;

`ifdef IOBUS_ROUTER_TIMEOUT_EN
  localparam int               CNT_W    = iobus_idx_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_tmo_cnt;
`endif

  iobus_addr_decode #(
    .BASE_ADDRESS  (BASE_ADDRESS),
    .ADDRESS_STRIDE(ADDRESS_STRIDE),
    .SLAVE_COUNT   (SLAVE_COUNT)
  ) u_decode (
    .i_address(bus.io_address),
    .o_hit    (w_hit),
    .o_sel    (w_sel),
    .o_offset (w_offset)
  );

  assign w_req        = bus.io_addr_strobe & (bus.io_read_strobe | bus.io_write_strobe);
  assign w_sel_onehot = SLAVE_COUNT'(1) << w_sel;
  assign w_sel_ready  = bus.s_ready[r_sel];
  assign w_sel_rdata  = bus.s_read_data[r_sel*32 +: 32];

  // Transaction FSM: decode in IDLE, one strobe cycle then wait in BUSY,
  // one-cycle completion pulse in RESP. All bus outputs are registered here.
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      r_state          <= IDLE;
      r_sel            <= '0;
      r_dir            <= IOBUS_READ;
      r_io_ready       <= 1'b0;
      r_bus_err        <= 1'b0;
      r_io_read_data   <= '0;
      r_s_addr_strobe  <= '0;
      r_s_read_strobe  <= '0;
      r_s_write_strobe <= '0;
      r_s_address      <= '0;
      r_s_byte_enable  <= '0;
      r_s_write_data   <= '0;
`ifdef IOBUS_ROUTER_TIMEOUT_EN
      r_tmo_cnt        <= '0;
`endif
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      r_io_ready       <= 1'b0;
      r_bus_err        <= 1'b0;
      r_s_addr_strobe  <= '0;
      r_s_read_strobe  <= '0;
      r_s_write_strobe <= '0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              r_sel           <= w_sel;
              r_dir           <= bus.io_write_strobe ? IOBUS_WRITE : IOBUS_READ;
              r_s_address     <= w_offset;
              r_s_byte_enable <= bus.io_byte_enable;
              r_s_write_data  <= bus.io_write_data;
              r_s_addr_strobe <= w_sel_onehot;
              if (bus.io_write_strobe) r_s_write_strobe <= w_sel_onehot;
              else                     r_s_read_strobe  <= w_sel_onehot;
`ifdef IOBUS_ROUTER_TIMEOUT_EN
              r_tmo_cnt       <= '0;
`endif
              r_state         <= BUSY;
            end else begin
              // Miss: slave-side registers keep their values, the write is dropped.
              r_io_ready     <= 1'b1;
              r_bus_err      <= 1'b1;
              r_io_read_data <= IOBUS_ERR_DATA;
              r_state        <= RESP;
            end
          end
        end
        BUSY: begin
          // A response in the last counted cycle still wins over the timeout.
          if (w_sel_ready) begin
            r_io_ready     <= 1'b1;
            r_io_read_data <= w_sel_rdata;
            r_state        <= RESP;
          end
`ifdef IOBUS_ROUTER_TIMEOUT_EN
          else if (r_tmo_cnt == CNT_LAST) begin
            r_io_ready     <= 1'b1;
            r_bus_err      <= 1'b1;
            r_io_read_data <= IOBUS_ERR_DATA;
            r_state        <= RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.io_ready       = r_io_ready;
  assign bus.io_read_data   = r_io_read_data;
  assign bus.bus_err        = r_bus_err;
  assign bus.s_addr_strobe  = r_s_addr_strobe;
  assign bus.s_read_strobe  = r_s_read_strobe;
  assign bus.s_write_strobe = r_s_write_strobe;
  assign bus.s_address      = r_s_address;
  assign bus.s_byte_enable  = r_s_byte_enable;
  assign bus.s_write_data   = r_s_write_data;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_iobus_router.sv
// tb_iobus_router: directed bench for iobus_router (4 slaves, 4 KiB windows
// at 0xC0000000, timeout of 8 cycles when IOBUS_ROUTER_TIMEOUT_EN is set).
module tb_iobus_router;
  import iobus_pkg::*;

  localparam logic [31:0] BASE   = 32'hC0000000;
  localparam logic [31:0] STRIDE = 32'h1000;
  localparam int          NSLV   = 4;
  localparam int          OFFW   = 12;
  localparam int          TMO    = 8;
  localparam int          OBS_N  = 1024;
  localparam logic [127:0] BG_DATA = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
`ifdef IOBUS_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic io_rst = 1'b1;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  iobus_router_state_t w_dbg_state;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iobus_router_if #(.SLAVE_COUNT(NSLV), .OFFSET_W(OFFW)) bus ();

  iobus_router #(
    .BASE_ADDRESS  (BASE),
    .ADDRESS_STRIDE(STRIDE),
    .SLAVE_COUNT   (NSLV),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .io_clk     (clk),
    .io_rst     (io_rst),
    .bus        (bus),
    .o_dbg_state(w_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int               sel;
    bit               we;
    logic [OFFW-1:0]  off;
    logic [3:0]       be;
    logic [31:0]      wd;
  } strobe_exp_t;

  strobe_exp_t exp_str[int];        // slave strobe expected in cycle (key)
  logic [31:0] exp_q[$];            // completion read data, in order
  int          exp_cyc_q[$];        // cycle of each completion
  bit          exp_err_q[$];        // bus_err with each completion
  bit          exp_chk_q[$];        // whether read data is meaningful

  // observed outputs per cycle, for hand-computed spot checks
  logic        obs_rdy [OBS_N];
  logic        obs_err [OBS_N];
  logic [31:0] obs_rd  [OBS_N];
  logic [3:0]  obs_as  [OBS_N];
  logic [3:0]  obs_rs  [OBS_N];
  logic [3:0]  obs_ws  [OBS_N];
  logic [OFFW-1:0] obs_sa [OBS_N];
  logic [3:0]  obs_be  [OBS_N];
  logic [31:0] obs_wd  [OBS_N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: transaction-level prediction from the address map and the reply
  // time chosen by the stimulus.
  task automatic model_txn(input int c, input logic [31:0] addr, input bit we,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int delay, input logic [31:0] rdata, input bit complete,
                           output bit hit, output int sel, output int done);
    longint a, b, span;
    logic [31:0] d;
    bit err, chk;
    a = longint'(addr);
    b = longint'(BASE);
    span = longint'(NSLV) * longint'(STRIDE);
    hit = (a >= b) && (a < b + span);
    sel = 0;
    if (hit) begin
      sel = int'((a - b) / longint'(STRIDE));
      exp_str[c + 1] = '{sel, we, OFFW'((a - b) % longint'(STRIDE)), be, wd};
      if (TO_EN && (delay < 0 || delay >= TMO)) begin
        done = c + 1 + TMO; d = 32'hffffffff; err = 1'b1; chk = 1'b1;
      end else begin
        done = c + 2 + delay; d = rdata; err = 1'b0; chk = !we;
      end
    end else begin
      done = c + 1; d = 32'hffffffff; err = 1'b1; chk = 1'b1;
    end
    if (complete) begin
      exp_q.push_back(d);
      exp_cyc_q.push_back(done);
      exp_err_q.push_back(err);
      exp_chk_q.push_back(chk);
    end
  endtask

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    logic [3:0] oh, ea, er, ew;
    if (cyc < OBS_N) begin
      obs_rdy[cyc] = bus.io_ready;      obs_err[cyc] = bus.bus_err;
      obs_rd[cyc]  = bus.io_read_data;  obs_as[cyc]  = bus.s_addr_strobe;
      obs_rs[cyc]  = bus.s_read_strobe; obs_ws[cyc]  = bus.s_write_strobe;
      obs_sa[cyc]  = bus.s_address;     obs_be[cyc]  = bus.s_byte_enable;
      obs_wd[cyc]  = bus.s_write_data;
    end
    if (chk_en) begin
      ea = '0; er = '0; ew = '0;
      if (exp_str.exists(cyc)) begin
        oh = 4'(1) << exp_str[cyc].sel;
        ea = oh;
        if (exp_str[cyc].we) ew = oh; else er = oh;
        check("s_address", 64'(bus.s_address), 64'(exp_str[cyc].off));
        check("s_byte_enable", 64'(bus.s_byte_enable), 64'(exp_str[cyc].be));
        if (exp_str[cyc].we) check("s_write_data", 64'(bus.s_write_data), 64'(exp_str[cyc].wd));
      end
      check("s_addr_strobe", 64'(bus.s_addr_strobe), 64'(ea));
      check("s_read_strobe", 64'(bus.s_read_strobe), 64'(er));
      check("s_write_strobe", 64'(bus.s_write_strobe), 64'(ew));
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        check("io_ready", 64'(bus.io_ready), 64'd1);
        check("bus_err", 64'(bus.bus_err), 64'(exp_err_q[0]));
        if (exp_chk_q[0]) check("io_read_data", 64'(bus.io_read_data), 64'(exp_q[0]));
        void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front());
        void'(exp_err_q.pop_front()); void'(exp_chk_q.pop_front());
      end else begin
        check("io_ready_idle", 64'(bus.io_ready), 64'd0);
        check("bus_err_idle", 64'(bus.bus_err), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input bit we,
                           input logic [3:0] be, input logic [31:0] wd);
    bus.io_addr_strobe  = 1'b1;
    bus.io_read_strobe  = !we;
    bus.io_write_strobe = we;
    bus.io_address      = addr;
    bus.io_byte_enable  = be;
    bus.io_write_data   = wd;
  endtask

  task automatic clear_req();
    bus.io_addr_strobe  = 1'b0;
    bus.io_read_strobe  = 1'b0;
    bus.io_write_strobe = 1'b0;
  endtask

  task automatic set_ready(input int k, input logic [31:0] d);
    bus.s_ready[k] = 1'b1;
    bus.s_read_data[k*32 +: 32] = d;
  endtask

  task automatic clear_ready();
    bus.s_ready     = '0;
    bus.s_read_data = BG_DATA;
  endtask

  // One master transaction; delay is cycles after the slave strobe until
  // s_ready (negative: the slave never answers and only pulses late).
  task automatic txn(input logic [31:0] addr, input bit we, input logic [3:0] be,
                     input logic [31:0] wd, input int delay, input logic [31:0] rdata,
                     input bit stray, input bit busy_req, input bit resp_req, output int c);
    bit hit; int sel; int done;
    c = cyc;
    model_txn(c, addr, we, be, wd, delay, rdata, 1'b1, hit, sel, done);
    drive_req(addr, we, be, wd);
    step();
    clear_req();
    for (int k = c + 1; k <= done + 1; k++) begin
      if (hit && delay >= 0 && k == c + 1 + delay) set_ready(sel, rdata);
      if (hit && delay < 0 && k == done + 1) set_ready(sel, rdata);
      if (hit && stray && k == c + 1) set_ready((sel == 0) ? 1 : 0, 32'h0BAD0BAD);
      if (busy_req && k == c + 2) drive_req(32'hC0000010, 1'b0, 4'hF, 32'h0);
      if (resp_req && k == done) drive_req(32'hC0001000, 1'b1, 4'hF, 32'h77777777);
      step();
      clear_req();
      clear_ready();
    end
  endtask

  // ---------------- directed vectors ----------------
  logic [31:0] v_addr [6] = '{32'hC0000000, 32'hC0000FFC, 32'hC0002ABC,
                              32'hC0003000, 32'hFFFFFFFC, 32'h00000000};
  bit          v_we   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0]  v_be   [6] = '{4'hF, 4'h3, 4'hF, 4'hC, 4'hF, 4'hF};
  logic [31:0] v_wd   [6] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h13579BDF};
  int          v_dly  [6] = '{0, 2, 4, 1, 0, 0};
  logic [31:0] v_rd   [6] = '{32'h00000001, 32'h0, 32'h89ABCDEF, 32'h5555AAAA, 32'h0, 32'h0};

  initial begin
    int c;
    bit h; int s; int d;
    bus.io_address = '0; bus.io_byte_enable = '0; bus.io_write_data = '0;
    clear_req();
    clear_ready();

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_io_ready", 64'(bus.io_ready), 64'd0);
    check("rst_io_read_data", 64'(bus.io_read_data), 64'd0);
    check("rst_bus_err", 64'(bus.bus_err), 64'd0);
    check("rst_strobes", 64'({bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe}), 64'd0);
    check("rst_s_bus", 64'({bus.s_address, bus.s_byte_enable, bus.s_write_data}), 64'd0);
    check("rst_state", 64'(w_dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    io_rst = 1'b0;
    chk_en = 1'b1;
    step();

    // read slave 1, answer one cycle after the strobe
    txn(32'hC0001004, 1'b0, 4'hF, 32'h0, 1, 32'h12345678, 1'b0, 1'b0, 1'b0, c);
    check("t1_rstrobe", 64'(obs_rs[c+1]), 64'h2);
    check("t1_saddr", 64'(obs_sa[c+1]), 64'h004);
    check("t1_not_early", 64'(obs_rdy[c+2]), 64'd0);
    check("t1_ready", 64'(obs_rdy[c+3]), 64'd1);
    check("t1_rdata", 64'(obs_rd[c+3]), 64'h12345678);

    // write last word of slave 3
    txn(32'hC0003FFC, 1'b1, 4'hF, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b0, 1'b0, c);
    check("t2_wstrobe", 64'(obs_ws[c+1]), 64'h8);
    check("t2_rstrobe", 64'(obs_rs[c+1]), 64'h0);
    check("t2_saddr", 64'(obs_sa[c+1]), 64'hFFC);
    check("t2_wdata", 64'(obs_wd[c+1]), 64'hDEADBEEF);
    check("t2_no_err", 64'(obs_err[c+2]), 64'd0);

    // unmapped write is discarded: slave-side registers keep the last hit
    txn(32'hC0010000, 1'b1, 4'h1, 32'h11111111, 0, 32'h0, 1'b0, 1'b0, 1'b0, c);
    check("t3_wd_kept", 64'(obs_wd[c+1]), 64'hDEADBEEF);
    check("t3_be_kept", 64'(obs_be[c+1]), 64'hF);

    // just past the last window, and just below the base
    txn(32'hC0004000, 1'b0, 4'hF, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0, c);
    check("t4_ready", 64'(obs_rdy[c+1]), 64'd1);
    check("t4_rdata", 64'(obs_rd[c+1]), 64'hffffffff);
    check("t4_err", 64'(obs_err[c+1]), 64'd1);
    txn(32'hBFFFFFFC, 1'b0, 4'hF, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0, c);
    check("t5_ready", 64'(obs_rdy[c+1]), 64'd1);
    check("t5_rdata", 64'(obs_rd[c+1]), 64'hffffffff);
    check("t5_err", 64'(obs_err[c+1]), 64'd1);

    // stray s_ready from slave 0 and a master strobe while slave 2 is busy
    txn(32'hC0002010, 1'b0, 4'hF, 32'h0, 3, 32'hA5A50002, 1'b1, 1'b1, 1'b0, c);
    check("t6_ready", 64'(obs_rdy[c+5]), 64'd1);
    check("t6_rdata", 64'(obs_rd[c+5]), 64'hA5A50002);
    check("t6_no_restrobe", 64'(obs_as[c+3]), 64'h0);

    // master strobe in the completion cycle is dropped
    txn(32'hC0005000, 1'b0, 4'hF, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b1, c);
    check("t7_dropped", 64'(obs_as[c+2] | obs_as[c+3]), 64'h0);

    // table of further directed vectors
    for (int i = 0; i < 6; i++)
      txn(v_addr[i], v_we[i], v_be[i], v_wd[i], v_dly[i], v_rd[i], 1'b0, 1'b0, 1'b0, c);

`ifdef IOBUS_ROUTER_TIMEOUT_EN
    // slave 2 never answers; then one answering in the last counted cycle
    txn(32'hC0002000, 1'b0, 4'hF, 32'h0, -1, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, c);
    check("to_not_early", 64'(obs_rdy[c+8]), 64'd0);
    check("to_ready", 64'(obs_rdy[c+9]), 64'd1);
    check("to_rdata", 64'(obs_rd[c+9]), 64'hffffffff);
    check("to_err", 64'(obs_err[c+9]), 64'd1);
    txn(32'hC0002000, 1'b0, 4'hF, 32'h0, TMO - 1, 32'h600DF00D, 1'b0, 1'b0, 1'b0, c);
    check("to_win_rdata", 64'(obs_rd[c+9]), 64'h600DF00D);
    check("to_win_err", 64'(obs_err[c+9]), 64'd0);
`endif

    // reset in the cycle after the slave strobe; late s_ready ignored
    c = cyc;
    model_txn(c, 32'hC0001008, 1'b0, 4'hF, 32'h0, 2, 32'h0, 1'b0, h, s, d);
    drive_req(32'hC0001008, 1'b0, 4'hF, 32'h0);
    step(); clear_req();
    step(); io_rst = 1'b1;
    step(); io_rst = 1'b0; set_ready(1, 32'h12121212);
    step(); clear_ready();
    step(); step();
    check("rr_ready", 64'(obs_rdy[c+3] | obs_rdy[c+4] | obs_rdy[c+5]), 64'd0);
    check("rr_rdata", 64'(obs_rd[c+3]), 64'd0);
    check("rr_s_bus", 64'({obs_sa[c+3], obs_be[c+3], obs_wd[c+3]}), 64'd0);
    check("rr_state", 64'(w_dbg_state), 64'(IDLE));

    // and the router works again afterwards
    txn(32'hC0000044, 1'b0, 4'hF, 32'h0, 1, 32'h44444444, 1'b0, 1'b0, 1'b0, c);
    step();
    check("no_pending", 64'(exp_cyc_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
